// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter
// Two-master AHB-Lite arbiter sharing the on-chip RAM slave between the
// Cortex-M0 (master 0) and the DMA engine (master 1). Each master has an
// address-phase holding register, so a master that loses arbitration or hits
// slave wait states is stalled through its own HREADY instead of losing the
// transfer. An uncontended transfer passes straight through in the same cycle.
//
// Configuration macro: AHB_ARB_RR_EN
//   defined   : round-robin tie-break on a 1-bit "last granted" pointer
//   undefined : fixed priority, master 0 over master 1
//
// Ports
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HADDRn/HTRANSn/HWRITEn/HSIZEn  master n address phase (n = 0, 1)
//   HWDATAn                      master n write data (data phase)
//   HRDATAn, HREADYn             read data / ready back to master n
//   HADDRS/HTRANSS/HWRITES/HSIZES  slave address phase
//   HWDATAS                      slave write data
//   HRDATAS, HREADYOUTS          slave read data / slave ready
//   HREADYS                      HREADY fed to the slave (= HREADYOUTS)

module ahb_ram_arbiter (
    input  logic        HCLK,
    input  logic        HRESET,
    // master 0
    input  logic [31:0] HADDR0,
    input  logic [1:0]  HTRANS0,
    input  logic        HWRITE0,
    input  logic [2:0]  HSIZE0,
    input  logic [31:0] HWDATA0,
    output logic [31:0] HRDATA0,
    output logic        HREADY0,
    // master 1
    input  logic [31:0] HADDR1,
    input  logic [1:0]  HTRANS1,
    input  logic        HWRITE1,
    input  logic [2:0]  HSIZE1,
    input  logic [31:0] HWDATA1,
    output logic [31:0] HRDATA1,
    output logic        HREADY1,
    // slave
    output logic [31:0] HADDRS,
    output logic [1:0]  HTRANSS,
    output logic        HWRITES,
    output logic [2:0]  HSIZES,
    output logic [31:0] HWDATAS,
    input  logic [31:0] HRDATAS,
    input  logic        HREADYOUTS,
    output logic        HREADYS
);

    // live master address phase, indexed by master
    logic [31:0] addr_l  [0:1];
    logic [1:0]  trans_l [0:1];
    logic        write_l [0:1];
    logic [2:0]  size_l  [0:1];

    // holding registers
    logic [1:0]  pend;
    logic [31:0] addr_h  [0:1];
    logic [1:0]  trans_h [0:1];
    logic        write_h [0:1];
    logic [2:0]  size_h  [0:1];

    // slave data phase ownership
    logic        d_val;
    logic        d_own;

    // selection of the previous cycle, and whether it was a stalled transfer
    logic        sel_q;
    logic        lock_q;

`ifdef AHB_ARB_RR_EN
    logic        last;
`endif

    logic [1:0]  ready;
    logic [1:0]  issue;
    logic [1:0]  cand;
    logic        arb_sel;
    logic        sel;
    logic        avalid;
    logic        commit;

    assign addr_l[0]  = HADDR0;
    assign addr_l[1]  = HADDR1;
    assign trans_l[0] = HTRANS0;
    assign trans_l[1] = HTRANS1;
    assign write_l[0] = HWRITE0;
    assign write_l[1] = HWRITE1;
    assign size_l[0]  = HSIZE0;
    assign size_l[1]  = HSIZE1;

    always_comb begin
        ready[0] = HRESET | ~(pend[0] | (d_val & ~d_own & ~HREADYOUTS));
        ready[1] = HRESET | ~(pend[1] | (d_val &  d_own & ~HREADYOUTS));
        issue[0] = ~HRESET & ready[0] & trans_l[0][1];
        issue[1] = ~HRESET & ready[1] & trans_l[1][1];
        cand     = (pend | issue) & {2{~HRESET}};

`ifdef AHB_ARB_RR_EN
        if (&cand)
            arb_sel = ~last;
        else
            arb_sel = ~cand[0] & cand[1];
`else
        arb_sel = ~cand[0] & cand[1];
`endif

        // A transfer stalled by slave wait states keeps the address bus.
        // It was captured into its hold register, so pend[sel_q] is set and
        // the hold register now presents the same values the live bus did.
        sel    = lock_q ? sel_q : arb_sel;
        avalid = cand[sel];
        commit = avalid & HREADYOUTS;
    end

    always_comb begin
        HTRANSS = 2'b00;
        HADDRS  = '0;
        HWRITES = 1'b0;
        HSIZES  = '0;
        if (avalid) begin
            if (pend[sel]) begin
                HTRANSS = trans_h[sel];
                HADDRS  = addr_h[sel];
                HWRITES = write_h[sel];
                HSIZES  = size_h[sel];
            end else begin
                HTRANSS = trans_l[sel];
                HADDRS  = addr_l[sel];
                HWRITES = write_l[sel];
                HSIZES  = size_l[sel];
            end
        end
    end

    assign HWDATAS = d_own ? HWDATA1 : HWDATA0;
    assign HRDATA0 = HRDATAS;
    assign HRDATA1 = HRDATAS;
    assign HREADY0 = ready[0];
    assign HREADY1 = ready[1];
    assign HREADYS = HREADYOUTS;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend   <= '0;
            d_val  <= 1'b0;
            d_own  <= 1'b0;
            sel_q  <= 1'b0;
            lock_q <= 1'b0;
            for (int unsigned m = 0; m < 2; m++) begin
                addr_h[m]  <= '0;
                trans_h[m] <= '0;
                write_h[m] <= 1'b0;
                size_h[m]  <= '0;
            end
`ifdef AHB_ARB_RR_EN
            last   <= 1'b1;
`endif
        end else begin
            sel_q  <= sel;
            lock_q <= avalid & ~HREADYOUTS;

            if (HREADYOUTS) begin
                d_val <= commit;
                if (commit)
                    d_own <= sel;
            end

            for (int unsigned m = 0; m < 2; m++) begin
                if (commit && (sel == m[0])) begin
                    pend[m] <= 1'b0;
                end else if (issue[m]) begin
                    pend[m]    <= 1'b1;
                    addr_h[m]  <= addr_l[m];
                    trans_h[m] <= trans_l[m];
                    write_h[m] <= write_l[m];
                    size_h[m]  <= size_l[m];
                end
            end

`ifdef AHB_ARB_RR_EN
            if (commit)
                last <= sel;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Self-checking bench for ahb_ram_arbiter: two queue-driven AHB master
// models, a RAM slave model with programmable wait states, and a per-master
// read-data scoreboard fed from a reference memory.

module tb_ahb_ram_arbiter;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR0, HADDR1;
    logic [1:0]  HTRANS0, HTRANS1;
    logic        HWRITE0, HWRITE1;
    logic [2:0]  HSIZE0, HSIZE1;
    logic [31:0] HWDATA0, HWDATA1;
    logic [31:0] HRDATA0, HRDATA1;
    logic        HREADY0, HREADY1;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [31:0] HWDATAS;
    logic [31:0] HRDATAS;
    logic        HREADYOUTS;
    logic        HREADYS;

    ahb_ram_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR0(HADDR0), .HTRANS0(HTRANS0), .HWRITE0(HWRITE0), .HSIZE0(HSIZE0),
        .HWDATA0(HWDATA0), .HRDATA0(HRDATA0), .HREADY0(HREADY0),
        .HADDR1(HADDR1), .HTRANS1(HTRANS1), .HWRITE1(HWRITE1), .HSIZE1(HSIZE1),
        .HWDATA1(HWDATA1), .HRDATA1(HRDATA1), .HREADY1(HREADY1),
        .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HWDATAS(HWDATAS), .HRDATAS(HRDATAS), .HREADYOUTS(HREADYOUTS),
        .HREADYS(HREADYS)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] patt(input int i);
        return 32'hC0DE_0000 ^ 32'(i * 4);
    endfunction

    // ---------------- RAM slave model ----------------
    logic [31:0] smem [0:1023];
    logic        s_dp, s_wr;
    logic [9:0]  s_idx;
    int unsigned s_cnt;
    int unsigned ws_next;

    assign HREADYOUTS = !(s_dp && s_cnt != 0);
    assign HRDATAS    = (s_dp && !s_wr) ? smem[s_idx] : 32'h0;

    always @(posedge HCLK) begin
        if (HRESET) begin
            s_dp  <= 1'b0;
            s_wr  <= 1'b0;
            s_idx <= '0;
            s_cnt <= 0;
            for (int i = 0; i < 1024; i++) smem[i] <= patt(i);
        end else if (HREADYOUTS) begin
            if (s_dp && s_wr) smem[s_idx] <= HWDATAS;
            s_dp  <= HTRANSS[1];
            s_wr  <= HWRITES;
            s_idx <= HADDRS[11:2];
            s_cnt <= ws_next;
        end else begin
            s_cnt <= s_cnt - 1;
        end
    end

    // ---------------- masters, reference and scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        rq  [2][$];
    logic [31:0] sbq [2][$];
    logic        gq  [$];
    req_t        cur [2];
    logic        cur_busy [2];
    logic        acc [2];
    logic        dp_act [2];
    logic        dp_wr [2];
    logic [31:0] wdat [2];
    logic [31:0] ref_mem [0:1023];
    int          rd_done [2];
    logic        rst_next;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        HRESET = rst_next;
        for (int m = 0; m < 2; m++) begin
            if (acc[m]) begin
                if (cur_busy[m] && cur[m].wr) wdat[m] = cur[m].data;
                if (rq[m].size() > 0) begin
                    cur[m] = rq[m].pop_front();
                    cur_busy[m] = 1'b1;
                end else begin
                    cur_busy[m] = 1'b0;
                end
            end
        end
        HADDR0  = cur_busy[0] ? cur[0].addr : 32'h0;
        HTRANS0 = cur_busy[0] ? 2'b10 : 2'b00;
        HWRITE0 = cur_busy[0] & cur[0].wr;
        HWDATA0 = wdat[0];
        HADDR1  = cur_busy[1] ? cur[1].addr : 32'h0;
        HTRANS1 = cur_busy[1] ? 2'b10 : 2'b00;
        HWRITE1 = cur_busy[1] & cur[1].wr;
        HWDATA1 = wdat[1];
    endtask

    task automatic monitor();
        logic        hr [2];
        logic [31:0] rd [2];
        if (HRESET) begin
            for (int m = 0; m < 2; m++) begin
                acc[m] = 1'b1;
                dp_act[m] = 1'b0;
                sbq[m].delete();
            end
            for (int i = 0; i < 1024; i++) ref_mem[i] = patt(i);
            return;
        end
        hr[0] = HREADY0; hr[1] = HREADY1;
        rd[0] = HRDATA0; rd[1] = HRDATA1;
        if (HREADYOUTS && HTRANSS[1] && gq.size() > 0)
            chk("grant", {31'b0, HADDRS[11]}, {31'b0, gq.pop_front()});
        for (int m = 0; m < 2; m++) begin
            if (hr[m]) begin
                if (dp_act[m] && !dp_wr[m]) begin
                    if (sbq[m].size() == 0)
                        chk($sformatf("sb_empty%0d", m), 32'(sbq[m].size()), 32'd1);
                    else
                        chk($sformatf("rdata%0d", m), rd[m], sbq[m].pop_front());
                    rd_done[m]++;
                end
                dp_act[m] = cur_busy[m];
                dp_wr[m]  = cur[m].wr;
                if (cur_busy[m]) begin
                    if (cur[m].wr) ref_mem[cur[m].addr[11:2]] = cur[m].data;
                    else sbq[m].push_back(ref_mem[cur[m].addr[11:2]]);
                end
                acc[m] = 1'b1;
            end else begin
                acc[m] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        drive();
        @(negedge HCLK);
        monitor();
    endtask

    task automatic push(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.wr = wr; r.addr = a; r.data = d;
        rq[m].push_back(r);
    endtask

    int b0, b1;

    initial begin
        HRESET = 1'b1; rst_next = 1'b1; ws_next = 0;
        HADDR0 = '0; HTRANS0 = '0; HWRITE0 = 1'b0; HWDATA0 = '0;
        HADDR1 = '0; HTRANS1 = '0; HWRITE1 = 1'b0; HWDATA1 = '0;
        HSIZE0 = 3'b010; HSIZE1 = 3'b010;
        for (int m = 0; m < 2; m++) begin
            acc[m] = 1'b1; cur_busy[m] = 1'b0; dp_act[m] = 1'b0; dp_wr[m] = 1'b0;
            wdat[m] = '0; rd_done[m] = 0; cur[m] = '0;
        end

        // reset: live request must be blocked from the slave
        tick(); tick();
        push(0, 1'b1, 32'h44, 32'hDEAD_BEEF);
        tick();
        chk("rst_htranss", {30'b0, HTRANSS}, 32'h0);
        chk("rst_haddrs", HADDRS, 32'h0);
        chk("rst_hwrites", {31'b0, HWRITES}, 32'h0);
        chk("rst_hsizes", {29'b0, HSIZES}, 32'h0);
        chk("rst_hready0", {31'b0, HREADY0}, 32'h1);
        chk("rst_hready1", {31'b0, HREADY1}, 32'h1);
        rst_next = 1'b0;
        tick();
        chk("idle_htranss", {30'b0, HTRANSS}, 32'h0);

        // single master write then read
        push(0, 1'b1, 32'h100, 32'h1234_5678);
        push(0, 1'b0, 32'h100, 32'h0);
        tick();
        chk("t1_htranss", {30'b0, HTRANSS}, 32'h2);
        chk("t1_haddrs_w", HADDRS, 32'h100);
        chk("t1_hwrites_w", {31'b0, HWRITES}, 32'h1);
        chk("t1_hsizes", {29'b0, HSIZES}, 32'h2);
        chk("t1_hready0_a", {31'b0, HREADY0}, 32'h1);
        tick();
        chk("t1_haddrs_r", HADDRS, 32'h100);
        chk("t1_hwrites_r", {31'b0, HWRITES}, 32'h0);
        chk("t1_hwdatas", HWDATAS, 32'h1234_5678);
        chk("t1_hready0_b", {31'b0, HREADY0}, 32'h1);
        tick();
        chk("t1_hready0_c", {31'b0, HREADY0}, 32'h1);
        chk("t1_hrdata0", HRDATA0, 32'h1234_5678);
        tick();

        // simultaneous issue, M0 wins, M1 captured
        push(0, 1'b0, 32'h200, 32'h0);
        push(1, 1'b1, 32'h300, 32'hA5A5_0300);
        tick();
        chk("t2_haddrs_m0", HADDRS, 32'h200);
        chk("t2_hwrites_m0", {31'b0, HWRITES}, 32'h0);
        chk("t2_hready1_a", {31'b0, HREADY1}, 32'h1);
        tick();
        chk("t2_hready1_b", {31'b0, HREADY1}, 32'h0);
        chk("t2_htranss_m1", {30'b0, HTRANSS}, 32'h2);
        chk("t2_haddrs_m1", HADDRS, 32'h300);
        chk("t2_hwrites_m1", {31'b0, HWRITES}, 32'h1);
        tick();
        chk("t2_hready1_c", {31'b0, HREADY1}, 32'h1);
        chk("t2_hwdatas", HWDATAS, 32'hA5A5_0300);
        push(1, 1'b0, 32'h300, 32'h0);
        tick(); tick(); tick();

        // slave wait states during an M1 read while M0 issues
        ws_next = 2;
        push(1, 1'b0, 32'h340, 32'h0);
        tick();
        chk("t3_haddrs_a", HADDRS, 32'h340);
        push(0, 1'b0, 32'h140, 32'h0);
        tick();
        ws_next = 0;
        chk("t3_hready1_b", {31'b0, HREADY1}, 32'h0);
        chk("t3_haddrs_b", HADDRS, 32'h140);
        tick();
        chk("t3_hready1_c", {31'b0, HREADY1}, 32'h0);
        chk("t3_hready0_c", {31'b0, HREADY0}, 32'h0);
        chk("t3_haddrs_c", HADDRS, 32'h140);
        tick();
        chk("t3_hready1_d", {31'b0, HREADY1}, 32'h1);
        chk("t3_hreadyouts_d", {31'b0, HREADYOUTS}, 32'h1);
        chk("t3_haddrs_d", HADDRS, 32'h140);
        tick();
        chk("t3_hready0_e", {31'b0, HREADY0}, 32'h1);
        tick(); tick();

        // reset with pend[1]=1 and a data phase in flight
        push(0, 1'b0, 32'h010, 32'h0);
        push(1, 1'b0, 32'h810, 32'h0);
        tick();
        rst_next = 1'b1;
        tick();
        chk("t5_rst_htranss", {30'b0, HTRANSS}, 32'h0);
        chk("t5_rst_hready0", {31'b0, HREADY0}, 32'h1);
        chk("t5_rst_hready1", {31'b0, HREADY1}, 32'h1);
        rst_next = 1'b0;
        tick();
        chk("t5_post_htranss", {30'b0, HTRANSS}, 32'h0);
        chk("t5_post_hready0", {31'b0, HREADY0}, 32'h1);
        chk("t5_post_hready1", {31'b0, HREADY1}, 32'h1);
        tick();
        chk("t5_post2_htranss", {30'b0, HTRANSS}, 32'h0);

        // both masters streaming reads
        b0 = rd_done[0];
        b1 = rd_done[1];
        for (int k = 0; k < 4; k++) begin
            push(0, 1'b0, 32'(k * 4), 32'h0);
            push(1, 1'b0, 32'h800 + 32'(k * 4), 32'h0);
        end
`ifdef AHB_ARB_RR_EN
        for (int k = 0; k < 8; k++) gq.push_back(k[0]);
`else
        for (int k = 0; k < 8; k++) gq.push_back(k >= 4);
`endif
        for (int k = 0; k < 14; k++) tick();
        chk("t4_grants_left", 32'(gq.size()), 32'd0);
        chk("t4_m0_done", 32'(rd_done[0] - b0), 32'd4);
        chk("t4_m1_done", 32'(rd_done[1] - b1), 32'd4);

        chk("sb_drain0", 32'(sbq[0].size()), 32'd0);
        chk("sb_drain1", 32'(sbq[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
